param_sram: RTL and testbench

- Parametrised single-port synchronous RAM: configurable data width, depth, output pipeline depth and read-during-write mode.
- Adds per-bit write mask, a request/ready/valid handshake and a hardware clear sequencer that fills memory with a constant after reset or on command.
- Serves as the general storage primitive for test designs and user logic.
- Maps onto fabric registers/LUT RAM; no vendor macros.

---
 rtl/param_sram.sv | 138 +++++++++++++
 tb/tb_param_sram.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sram.sv
// Single-port synchronous RAM with per-bit write mask, fixed-latency
// read response pipeline and a hardware clear sweep.
module param_sram #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_PIPE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Request,
  input  logic                  i_WriteEnable,
  input  logic [DATA_WIDTH-1:0] i_WriteMask,
  input  logic [ADDR_WIDTH-1:0] i_Address,
  input  logic [DATA_WIDTH-1:0] i_DataIn,
  input  logic                  i_Clear,
  output logic                  o_Ready,
  output logic                  o_Busy,
  output logic                  o_ReadValid,
  output logic [DATA_WIDTH-1:0] o_DataOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LAT   = 1 + OUT_PIPE;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_mrg;
  logic [DATA_WIDTH-1:0] rsp_d;

  logic [LAT-1:0]        vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [LAT];
  logic [DATA_WIDTH-1:0] dat_d [LAT];

  assign o_Ready = (state_q == S_RUN);
  assign o_Busy  = (state_q == S_CLEAR);
  assign accept  = i_Request & o_Ready & ~i_Clear;

  assign rd_old = mem_q[i_Address];
  assign rd_mrg = (rd_old & ~i_WriteMask)
                | (i_DataIn & i_WriteMask);

  // Write-through returns the merged word only for writes.
  assign rsp_d = (i_WriteEnable && RDW_MODE != 0)
               ? rd_mrg : rd_old;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = i_Address;
    mem_wd  = rd_mrg;
    unique case (state_q)
      S_RUN: begin
        if (i_Clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (accept && i_WriteEnable) begin
          mem_we = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = CLEAR_VALUE;
        cnt_d  = cnt_q + 1'b1;
        if (i_Clear) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Data stages only load on a valid so the output holds between pulses.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    dat_d[0] = accept ? rsp_d : dat_q[0];
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < LAT; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign o_ReadValid = vld_q[LAT-1];
  assign o_DataOut   = dat_q[LAT-1];

endmodule

// File: tb/tb_param_sram.sv
// Bench for param_sram: two configurations share one stimulus stream
// and are checked every cycle against a word-level reference model.
module tb_param_sram;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       req, we, clr;
  logic [3:0] mask, addr, din;
  logic [1:0] rdy, busy, rv;
  logic [3:0] dout0, dout1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] rd0[$];
  logic [3:0] rd1[$];
  int         rc0[$];
  int         rc1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // inst 0: defaults; inst 1: write-through, 2 extra stages, no clear on reset
  param_sram u_dut0 (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Request(req), .i_WriteEnable(we),
    .i_WriteMask(mask), .i_Address(addr),
    .i_DataIn(din), .i_Clear(clr),
    .o_Ready(rdy[0]), .o_Busy(busy[0]),
    .o_ReadValid(rv[0]), .o_DataOut(dout0)
  );

  param_sram #(
    .DATA_WIDTH(4), .ADDR_WIDTH(4), .RDW_MODE(1),
    .OUT_PIPE(2), .CLEAR_ON_RESET(0), .CLEAR_VALUE(4'h6)
  ) u_dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Request(req), .i_WriteEnable(we),
    .i_WriteMask(mask), .i_Address(addr),
    .i_DataIn(din), .i_Clear(clr),
    .o_Ready(rdy[1]), .o_Busy(busy[1]),
    .o_ReadValid(rv[1]), .o_DataOut(dout1)
  );

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic bit rdwm(int i);
    return (i == 1);
  endfunction
  function automatic bit cor(int i);
    return (i == 0);
  endfunction
  function automatic logic [3:0] cval(int i);
    return (i == 0) ? 4'h0 : 4'h6;
  endfunction
  function automatic logic [3:0] dout_of(int i);
    return (i == 0) ? dout0 : dout1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: memory words plus a known-bit mask, and a
  // schedule of responses keyed by the cycle they must appear.
  logic [3:0] mm [2][16];
  logic [3:0] mk [2][16];
  bit         mclr [2];
  int         mcnt [2];
  int         mcyc;
  bit         sv [2][64];
  logic [3:0] sd [2][64];
  logic [3:0] sk [2][64];
  bit         ev [2];
  logic [3:0] ed [2];
  logic [3:0] ek [2];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++) begin
        mm[i][a] = 4'h0;
        mk[i][a] = 4'h0;
      end
  end

  task automatic model_reset();
    mcyc = 0;
    for (int i = 0; i < 2; i++) begin
      mclr[i] = cor(i);
      mcnt[i] = 0;
      ev[i]   = 1'b0;
      ed[i]   = 4'h0;
      ek[i]   = 4'hF;
      for (int s = 0; s < 64; s++) sv[i][s] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0] o, ok, mg, mgk, r, rk;
    int s;
    if (req && !mclr[i] && !clr) begin
      o   = mm[i][addr];
      ok  = mk[i][addr];
      mg  = (o & ~mask) | (din & mask);
      mgk = ok | mask;
      r   = (we && rdwm(i)) ? mg : o;
      rk  = (we && rdwm(i)) ? mgk : ok;
      if (we) begin
        mm[i][addr] = mg;
        mk[i][addr] = mgk;
      end
      s = (mcyc + lat(i) - 1) % 64;
      sv[i][s] = 1'b1;
      sd[i][s] = r;
      sk[i][s] = rk;
    end
    if (mclr[i]) begin
      mm[i][mcnt[i]] = cval(i);
      mk[i][mcnt[i]] = 4'hF;
    end
    if (clr) begin
      mclr[i] = 1'b1;
      mcnt[i] = 0;
    end else if (mclr[i]) begin
      if (mcnt[i] == 15) mclr[i] = 1'b0;
      mcnt[i] = (mcnt[i] + 1) % 16;
    end
    s = mcyc % 64;
    if (sv[i][s]) begin
      ev[i] = 1'b1;
      ed[i] = sd[i][s];
      ek[i] = sk[i][s];
      sv[i][s] = 1'b0;
    end else begin
      ev[i] = 1'b0;
    end
  endtask

  task automatic model_tick();
    if (!rst_n) begin
      model_reset();
    end else begin
      mcyc++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  endtask

  always @(posedge clk or negedge rst_n) model_tick();

  task automatic compare_all();
    logic [3:0] d;
    for (int i = 0; i < 2; i++) begin
      d = dout_of(i);
      chk($sformatf("ready%0d c%0d", i, cyc), int'(rdy[i]), int'(!mclr[i]));
      chk($sformatf("busy%0d c%0d", i, cyc), int'(busy[i]), int'(mclr[i]));
      chk($sformatf("valid%0d c%0d", i, cyc), int'(rv[i]), int'(ev[i]));
      chk($sformatf("data%0d c%0d", i, cyc), int'(d & ek[i]), int'(ed[i] & ek[i]));
    end
    if (rv[0]) begin rd0.push_back(dout0); rc0.push_back(cyc); end
    if (rv[1]) begin rd1.push_back(dout1); rc1.push_back(cyc); end
  endtask

  always @(negedge clk) if (rst_n) compare_all();

  function automatic int g0(int k);
    if (k < 0 || k >= rd0.size()) return -1;
    return int'(rd0[k]);
  endfunction
  function automatic int g1(int k);
    if (k < 0 || k >= rd1.size()) return -1;
    return int'(rd1[k]);
  endfunction
  function automatic int c0(int k);
    if (k < 0 || k >= rc0.size()) return -1;
    return rc0[k];
  endfunction
  function automatic int c1(int k);
    if (k < 0 || k >= rc1.size()) return -1;
    return rc1[k];
  endfunction

  task automatic drive(input bit r, input bit w, input logic [3:0] m,
                       input logic [3:0] a, input logic [3:0] d,
                       input bit c);
    req = r; we = w; mask = m; addr = a; din = d; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic count_busy(input int i, input int clr_at,
                            input bit r_busy, output int n);
    n = 0;
    while (!rdy[i] && n < 200) begin
      n++;
      req  = r_busy;
      we   = 1'b0;
      addr = 4'($urandom);
      clr  = (n == clr_at);
      @(negedge clk);
    end
    req = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, b1, rq, e0, e1;
    req = 0; we = 0; clr = 0; mask = 0; addr = 0; din = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready1_after_reset", int'(rdy[1]), 1);
    count_busy(0, 0, 1'b0, n);
    chk("reset_sweep_cycles", n, 16);

    b0 = rd0.size();
    rq = cyc;
    for (int a = 0; a < 16; a++) drive(1, 0, 4'h0, 4'(a), 4'h0, 0);
    idle(4);
    chk("read_all_count", rd0.size() - b0, 16);
    chk("read_all_lat", c0(b0) - rq, 1);
    e0 = 0;
    for (int k = 0; k < 16; k++) if (g0(b0 + k) != 0) e0++;
    chk("read_all_zero", e0, 0);

    b0 = rd0.size();
    b1 = rd1.size();
    drive(1, 1, 4'hF, 4'h5, 4'hA, 0);
    drive(1, 1, 4'h3, 4'h5, 4'h5, 0);
    drive(1, 0, 4'h0, 4'h5, 4'h0, 0);
    idle(5);
    chk("rdw0_wr1", g0(b0), 0);
    chk("rdw0_wr2_old", g0(b0 + 1), 10);
    chk("rdw0_read", g0(b0 + 2), 9);
    chk("rdw1_wr1_new", g1(b1), 10);
    chk("rdw1_wr2_new", g1(b1 + 1), 9);
    chk("rdw1_read", g1(b1 + 2), 9);

    for (int a = 0; a < 16; a++) drive(1, 1, 4'hF, 4'(a), 4'(a), 0);
    idle(4);
    b1 = rd1.size();
    rq = cyc;
    for (int a = 0; a < 16; a++) drive(1, 0, 4'h0, 4'(a), 4'h0, 0);
    idle(6);
    chk("pipe_count", rd1.size() - b1, 16);
    chk("pipe_lat", c1(b1) - rq, 3);
    e0 = 0;
    e1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (g1(b1 + k) != k) e0++;
      if (c1(b1 + k) != c1(b1) + k) e1++;
    end
    chk("pipe_data_order", e0, 0);
    chk("pipe_back_to_back", e1, 0);

    b0 = rd0.size();
    b1 = rd1.size();
    drive(1, 0, 4'h0, 4'h3, 4'h0, 1);
    count_busy(0, 0, 1'b0, n);
    chk("clear_cycles", n, 16);
    idle(4);
    chk("clear_req_drop0", rd0.size() - b0, 0);
    chk("clear_req_drop1", rd1.size() - b1, 0);

    b0 = rd0.size();
    b1 = rd1.size();
    for (int a = 0; a < 16; a++) drive(1, 0, 4'h0, 4'(a), 4'h0, 0);
    idle(5);
    e0 = 0;
    e1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (g0(b0 + k) != 0) e0++;
      if (g1(b1 + k) != 6) e1++;
    end
    chk("cleared0_zero", e0, 0);
    chk("cleared1_six", e1, 0);

    b0 = rd0.size();
    b1 = rd1.size();
    drive(0, 0, 4'h0, 4'h0, 4'h0, 1);
    count_busy(0, 8, 1'b1, n);
    chk("restart_cycles", n, 24);
    idle(4);
    chk("busy_req_drop0", rd0.size() - b0, 0);
    chk("busy_req_drop1", rd1.size() - b1, 0);

    repeat (600)
      drive(($urandom % 4) != 0, 1'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), ($urandom % 60) == 0);
    idle(6);
    count_busy(0, 0, 1'b0, n);
    count_busy(1, 0, 1'b0, n);

    b1 = rd1.size();
    req = 1; we = 0; addr = 4'h7; clr = 0;
    @(posedge clk);
    #2;
    chk("pre_reset_valid0", int'(rv[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid0", int'(rv[0]), 0);
    chk("async_valid1", int'(rv[1]), 0);
    chk("async_data0", int'(dout0), 0);
    chk("async_data1", int'(dout1), 0);
    req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("ready1_after_reset2", int'(rdy[1]), 1);
    count_busy(0, 0, 1'b0, n);
    chk("reset2_sweep_cycles", n, 16);
    idle(4);
    chk("stale_rsp_dropped", rd1.size() - b1, 0);

    drive(0, 0, 4'h0, 4'h0, 4'h0, 1);
    idle(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsweep_busy0", int'(busy[0]), 1);
    chk("midsweep_ready1", int'(rdy[1]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(0, 0, 1'b0, n);
    chk("midsweep_restart", n, 16);
    repeat (64)
      drive(1, 0, 4'h0, 4'($urandom), 4'h0, 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
